pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  Power-up and lock supervisor for the board PLL (GW5A PLLA, 50 MHz in).
//  Runs on the free-running 50 MHz input clock. Pulses the PLL RESET and waits for LOCK,
//  retrying on timeout. Releases the system reset only after LOCK has been stable.
//  Re-sequences on loss of lock or on a restart request (e.g. video-mode PLL change from the MCU).
// PARAMETERS
//  RESET_CYCLES        16      cycles pll_reset is held high per attempt (>=1)
//  LOCK_STABLE_CYCLES  1024    cycles synced lock must stay high before release (>=1)
//  LOCK_TIMEOUT        500000  cycles allowed in WAIT_LOCK per attempt (10 ms @50 MHz)
//  MAX_RETRIES         4       extra attempts after the first; range 0..7
//  CNT_W               20      counter width; must hold max(all cycle params)-1
//  LOSS_FILTER         4       lock-low cycles that count as loss (only with macro)
// PORTS
//  clk          in   1  free-running 50 MHz reference clock (same net as PLL clkin)
//  reset_n      in   1  asynchronous, active-low reset
//  pll_lock     in   1  PLL LOCK, asynchronous to clk
//  ext_restart  in   1  clk-synchronous one-cycle request to re-sequence
//  pll_reset    out  1  to PLL RESET, active high
//  sys_reset_n  out  1  system reset to downstream logic, active low
//  locked       out  1  high only in RUN
//  fail         out  1  high only in FAIL
//  retry_cnt    out  3  retries consumed since last reset/ext_restart
// BEHAVIOUR
//  - pll_lock passes a 2-FF synchronizer (reset 0) -> lock_s. All outputs are registered.
//    Outputs are decoded from next-state, so they change on the edge that enters a state.
//  - Reset values: state=RST_PLL, cnt=0, pll_reset=1, sys_reset_n=0, locked=0, fail=0, retry_cnt=0.
//  - RST_PLL: pll_reset=1. If cnt==RESET_CYCLES-1 -> WAIT_LOCK, cnt=0; else cnt++.
//  - WAIT_LOCK: pll_reset=0.
//      - If lock_s=1 -> STABLE, cnt=0.
//      - Else if cnt==LOCK_TIMEOUT-1:
//          - retry_cnt==MAX_RETRIES -> FAIL.
//          - Otherwise retry_cnt++ and -> RST_PLL, cnt=0.
//      - Else cnt++.
//  - STABLE:
//      - If lock_s=0 -> WAIT_LOCK, cnt=0. retry_cnt is unchanged and the timeout restarts.
//      - Else if cnt==LOCK_STABLE_CYCLES-1 -> RUN.
//      - Else cnt++.
//  - RUN: sys_reset_n=1, locked=1. A lock loss -> RST_PLL, cnt=0; retry_cnt unchanged.
//    sys_reset_n drops on that same edge.
//  - FAIL: pll_reset=0, sys_reset_n=0, fail=1. Exited only by ext_restart or reset_n.
//  - ext_restart has priority in every state: -> RST_PLL, cnt=0, retry_cnt=0, fail=0.
//    In RST_PLL it restarts the pulse count.
//  - Total attempts before FAIL = MAX_RETRIES+1. retry_cnt never exceeds MAX_RETRIES.
//  - Latency: lock_s first high at edge E -> sys_reset_n=1 after edge E+1+LOCK_STABLE_CYCLES.
//    With no glitches, pll_lock sampled high at edge N gives sys_reset_n=1 after edge
//    N+LOCK_STABLE_CYCLES+2.
//  - reset_n low mid-operation forces reset values immediately (async). Sequencing restarts
//    from RST_PLL on release.
// CONFIGURATION
//  PLL_SEQ_LOSS_FILTER_EN
//  - Defined: in RUN, a loss is declared only after lock_s=0 for LOSS_FILTER consecutive
//    cycles. Uses a separate filter counter, cleared whenever lock_s=1 or outside RUN.
//    Shorter low pulses are ignored.
//  - Undefined: a single lock_s=0 cycle in RUN is a loss. The filter counter and LOSS_FILTER
//    are not synthesized. STABLE is never filtered in either build.
// TESTING (bench params: RESET_CYCLES=4 LOCK_STABLE_CYCLES=8 LOCK_TIMEOUT=32 MAX_RETRIES=2)
//  1. Release reset_n; set pll_lock=1 at cycle 10.
//     -> pll_reset high for exactly 4 cycles after release.
//     -> sys_reset_n=1 and locked=1 exactly 10 edges after the first edge sampling pll_lock=1.
//  2. pll_lock held 0 forever.
//     -> three 4-cycle pll_reset pulses, 32 cycles apart; retry_cnt steps 0->1->2.
//     -> then fail=1, pll_reset=0, sys_reset_n=0, held.
//  3. In RUN, pll_lock low for 1 cycle (macro off).
//     -> sys_reset_n=0 and pll_reset=1 3 edges later; retry_cnt unchanged.
//     -> full re-lock sequence follows.
//  4. In FAIL, pulse ext_restart.
//     -> next edge: fail=0, retry_cnt=0, pll_reset=1; a normal sequence follows.
//  5. Assert reset_n mid-STABLE (cnt=5).
//     -> all outputs at reset values without a clock edge; after release, restart from RST_PLL.
//  6. Macro on, LOSS_FILTER=4, in RUN:
//     -> a 3-cycle pll_lock low leaves locked=1.
//     -> a 4-cycle low drops sys_reset_n 4 edges after lock_s first goes low.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//   Power-up and lock supervisor for the board PLL. Runs on the free-running
//   reference clock. It pulses the PLL reset and waits for LOCK, retrying on
//   timeout. The system reset is released only after LOCK has stayed high for
//   a stable window. The block re-sequences on loss of lock or on ext_restart.
//
// Ports
//   clk          in   free-running reference clock (same net as PLL clkin)
//   reset_n      in   asynchronous active-low reset
//   pll_lock     in   PLL LOCK, asynchronous to clk
//   ext_restart  in   clk-synchronous one-cycle re-sequence request
//   pll_reset    out  PLL RESET, active high
//   sys_reset_n  out  downstream system reset, active low
//   locked       out  high only in RUN
//   fail         out  high only in FAIL
//   retry_cnt    out  retries consumed since last reset/ext_restart
//
// Build option
//   PLL_SEQ_LOSS_FILTER_EN : when defined, a loss of lock in RUN is declared
//   only after LOSS_FILTER consecutive low cycles of the synchronised lock.
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
   parameter int unsigned RESET_CYCLES       = 16,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned LOCK_TIMEOUT       = 500000,
   parameter int unsigned MAX_RETRIES        = 4,
   parameter int unsigned CNT_W              = 20
`ifdef PLL_SEQ_LOSS_FILTER_EN
   ,
   parameter int unsigned LOSS_FILTER        = 4
`endif
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pll_lock,
   input  logic       ext_restart,
   output logic       pll_reset,
   output logic       sys_reset_n,
   output logic       locked,
   output logic       fail,
   output logic [2:0] retry_cnt
);

   localparam logic [2:0] ST_RST_PLL   = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_STABLE    = 3'd2;
   localparam logic [2:0] ST_RUN       = 3'd3;
   localparam logic [2:0] ST_FAIL      = 3'd4;

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRIES);

   logic             lock_meta;
   logic             lock_s;
   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [2:0]       retry_nxt;
   logic             run_loss;

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_s    <= lock_meta;
      end
   end

`ifdef PLL_SEQ_LOSS_FILTER_EN
   localparam logic [CNT_W-1:0] FLT_LAST = CNT_W'(LOSS_FILTER - 1);
   logic [CNT_W-1:0] flt_cnt;

   // Loss is declared on the LOSS_FILTER-th consecutive low cycle.
   assign run_loss = !lock_s && (flt_cnt == FLT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flt_cnt <= '0;
      end else if (lock_s || (state != ST_RUN)) begin
         flt_cnt <= '0;
      end else if (!run_loss) begin
         flt_cnt <= flt_cnt + CNT_W'(1);
      end
   end
`else
   assign run_loss = !lock_s;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      retry_nxt = retry_cnt;
      if (ext_restart) begin
         state_nxt = ST_RST_PLL;
         cnt_nxt   = '0;
         retry_nxt = '0;
      end else begin
         case (state)
            ST_RST_PLL: begin
               if (cnt == RST_LAST) begin
                  state_nxt = ST_WAIT_LOCK;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt = ST_STABLE;
                  cnt_nxt   = '0;
               end else if (cnt == TO_LAST) begin
                  if (retry_cnt == RETRY_MAX) begin
                     state_nxt = ST_FAIL;
                  end else begin
                     retry_nxt = retry_cnt + 3'd1;
                     state_nxt = ST_RST_PLL;
                     cnt_nxt   = '0;
                  end
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            ST_STABLE: begin
               if (!lock_s) begin
                  state_nxt = ST_WAIT_LOCK;
                  cnt_nxt   = '0;
               end else if (cnt == STB_LAST) begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (run_loss) begin
                  state_nxt = ST_RST_PLL;
                  cnt_nxt   = '0;
               end
            end
            ST_FAIL: begin
               state_nxt = ST_FAIL;
            end
            default: begin
               state_nxt = ST_RST_PLL;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Outputs decode the next state so they change on the edge entering it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_RST_PLL;
         cnt         <= '0;
         retry_cnt   <= '0;
         pll_reset   <= 1'b1;
         sys_reset_n <= 1'b0;
         locked      <= 1'b0;
         fail        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         retry_cnt   <= retry_nxt;
         pll_reset   <= (state_nxt == ST_RST_PLL);
         sys_reset_n <= (state_nxt == ST_RUN);
         locked      <= (state_nxt == ST_RUN);
         fail        <= (state_nxt == ST_FAIL);
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Directed bench for pll_lock_sequencer with RESET_CYCLES=4,
//   LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRIES=2 (LOSS_FILTER=4 when
//   PLL_SEQ_LOSS_FILTER_EN is defined). Edge numbers below count rising edges
//   after reset release; outputs are sampled 1 ns after each edge.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

   logic       clk;
   logic       reset_n;
   logic       pll_lock;
   logic       ext_restart;
   logic       pll_reset;
   logic       sys_reset_n;
   logic       locked;
   logic       fail;
   logic [2:0] retry_cnt;
   logic [6:0] outs;

   int unsigned n_checks;
   int unsigned n_errors;

   pll_lock_sequencer #(
      .RESET_CYCLES       (4),
      .LOCK_STABLE_CYCLES (8),
      .LOCK_TIMEOUT       (32),
      .MAX_RETRIES        (2),
      .CNT_W              (20)
`ifdef PLL_SEQ_LOSS_FILTER_EN
      ,
      .LOSS_FILTER        (4)
`endif
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pll_lock    (pll_lock),
      .ext_restart (ext_restart),
      .pll_reset   (pll_reset),
      .sys_reset_n (sys_reset_n),
      .locked      (locked),
      .fail        (fail),
      .retry_cnt   (retry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign outs = {pll_reset, sys_reset_n, locked, fail, retry_cnt};

   typedef struct {
      int unsigned n;
      logic        lock;
      logic [6:0]  exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [6:0] o(input logic pr, input logic srn, input logic lk,
                                    input logic fl, input logic [2:0] rc);
      return {pr, srn, lk, fl, rc};
   endfunction

   function automatic vec_t mk(input int unsigned n, input logic lock,
                               input logic [6:0] exp, input string name);
      vec_t v;
      v.n    = n;
      v.lock = lock;
      v.exp  = exp;
      v.name = name;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [6:0] exp);
      n_checks++;
      if (outs !== exp) begin
         n_errors++;
         $display("FAIL %s: got {pr,srn,lk,fail,rc}=%b want %b at %0t", name, outs, exp, $time);
      end
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      reset_n     = 1'b0;
      pll_lock    = 1'b0;
      ext_restart = 1'b0;

      // Power-up: lock arrives at edge 10, RUN at edge 20.
      vecs.push_back(mk(3,  1'b0, o(1,0,0,0,3'd0), "rst_pulse_e3"));
      vecs.push_back(mk(1,  1'b0, o(0,0,0,0,3'd0), "rst_pulse_end_e4"));
      vecs.push_back(mk(5,  1'b0, o(0,0,0,0,3'd0), "wait_lock_e9"));
      vecs.push_back(mk(10, 1'b1, o(0,0,0,0,3'd0), "stable_e19"));
      vecs.push_back(mk(1,  1'b1, o(0,1,1,0,3'd0), "run_e20"));
`ifdef PLL_SEQ_LOSS_FILTER_EN
      // 3-cycle low ignored; 4-cycle low (driven before edges 31..34) drops at edge 36.
      vecs.push_back(mk(3, 1'b0, o(0,1,1,0,3'd0), "filt_low3_e23"));
      vecs.push_back(mk(3, 1'b1, o(0,1,1,0,3'd0), "filt_low3_hold_e26"));
      vecs.push_back(mk(4, 1'b1, o(0,1,1,0,3'd0), "filt_settle_e30"));
      vecs.push_back(mk(4, 1'b0, o(0,1,1,0,3'd0), "filt_low4_e34"));
      vecs.push_back(mk(1, 1'b1, o(0,1,1,0,3'd0), "filt_low4_e35"));
      vecs.push_back(mk(1, 1'b1, o(1,0,0,0,3'd0), "filt_loss_e36"));
      vecs.push_back(mk(3, 1'b1, o(1,0,0,0,3'd0), "relock_rst_e39"));
      vecs.push_back(mk(1, 1'b1, o(0,0,0,0,3'd0), "relock_wait_e40"));
      vecs.push_back(mk(8, 1'b1, o(0,0,0,0,3'd0), "relock_stable_e48"));
      vecs.push_back(mk(1, 1'b1, o(0,1,1,0,3'd0), "relock_run_e49"));
`else
      // Single low cycle sampled at edge 21 drops the system reset at edge 23.
      vecs.push_back(mk(1, 1'b0, o(0,1,1,0,3'd0), "glitch_e21"));
      vecs.push_back(mk(1, 1'b1, o(0,1,1,0,3'd0), "glitch_e22"));
      vecs.push_back(mk(1, 1'b1, o(1,0,0,0,3'd0), "loss_e23"));
      vecs.push_back(mk(3, 1'b1, o(1,0,0,0,3'd0), "relock_rst_e26"));
      vecs.push_back(mk(1, 1'b1, o(0,0,0,0,3'd0), "relock_wait_e27"));
      vecs.push_back(mk(8, 1'b1, o(0,0,0,0,3'd0), "relock_stable_e35"));
      vecs.push_back(mk(1, 1'b1, o(0,1,1,0,3'd0), "relock_run_e36"));
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("reset_values", o(1,0,0,0,3'd0));
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         pll_lock = vecs[i].lock;
         repeat (vecs[i].n) tick();
         chk(vecs[i].name, vecs[i].exp);
      end

      // Async reset in RUN, then again mid-STABLE (cnt=5 after edge 10).
      reset_n = 1'b0;
      #1;
      chk("async_reset_run", o(1,0,0,0,3'd0));
      reset_n  = 1'b1;
      pll_lock = 1'b1;
      repeat (3) tick();
      chk("ar_rst_e3", o(1,0,0,0,3'd0));
      tick();
      chk("ar_wait_e4", o(0,0,0,0,3'd0));
      repeat (6) tick();
      chk("ar_stable_e10", o(0,0,0,0,3'd0));
      reset_n = 1'b0;
      #1;
      chk("async_reset_stable", o(1,0,0,0,3'd0));
      #1;
      reset_n = 1'b1;
      repeat (4) tick();
      chk("ar2_wait_e4", o(0,0,0,0,3'd0));
      repeat (8) tick();
      chk("ar2_stable_e12", o(0,0,0,0,3'd0));
      tick();
      chk("ar2_run_e13", o(0,1,1,0,3'd0));

      // Lock never arrives: pulses at edges 0, 36, 72; FAIL from edge 108.
      reset_n  = 1'b0;
      pll_lock = 1'b0;
      #1;
      reset_n = 1'b1;
      for (int e = 1; e <= 115; e++) begin
         logic       pr;
         logic [2:0] rc;
         tick();
         pr = (e < 4) || (e >= 36 && e < 40) || (e >= 72 && e < 76);
         rc = (e >= 72) ? 3'd2 : ((e >= 36) ? 3'd1 : 3'd0);
         chk($sformatf("timeout_e%0d", e), o(pr, 1'b0, 1'b0, (e >= 108), rc));
      end

      // Restart from FAIL, then a second restart inside RST_PLL restarts the pulse.
      ext_restart = 1'b1;
      pll_lock    = 1'b1;
      tick();
      ext_restart = 1'b0;
      chk("restart_from_fail", o(1,0,0,0,3'd0));
      repeat (2) tick();
      ext_restart = 1'b1;
      tick();
      ext_restart = 1'b0;
      chk("restart_in_rst", o(1,0,0,0,3'd0));
      repeat (3) tick();
      chk("restart_pulse_last", o(1,0,0,0,3'd0));
      tick();
      chk("restart_pulse_end", o(0,0,0,0,3'd0));
      repeat (8) tick();
      chk("restart_stable", o(0,0,0,0,3'd0));
      tick();
      chk("restart_run", o(0,1,1,0,3'd0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
